// File: rtl/dpi_mem_ctrl.sv
// rtl/dpi_mem_ctrl.sv - fixed-latency valid/ready memory controller backed by the pmem model
// One request in flight; the model is touched exactly once, on the edge that enters RESP.
module dpi_mem_ctrl #(
  parameter int unsigned LATENCY = 1,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter logic [31:0] SIZE    = 32'h0800_0000,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  if (LATENCY < 1 || LATENCY > 16) begin : g_bad_latency
    $error("dpi_mem_ctrl: LATENCY must be within 1..16");
  end
  if (SIZE == 32'd0 || SIZE[1:0] != 2'b00) begin : g_bad_size
    $error("dpi_mem_ctrl: SIZE must be a non-zero multiple of 4");
  end
  if ((LATENCY - 1) >= (32'd1 << CNT_W)) begin : g_bad_cnt_w
    $error("dpi_mem_ctrl: CNT_W too narrow for LATENCY-1");
  end

  // In-language stand-in for the C memory model, with call counters for observation.
  logic [31:0] pmem [int unsigned];
  int unsigned rd_calls;
  int unsigned wr_calls;

  function automatic int unsigned dpi_pmem_read(input int unsigned addr);
    rd_calls = rd_calls + 1;
    return pmem.exists(addr) ? pmem[addr] : 32'h0;
  endfunction

  function automatic void dpi_pmem_write(input int unsigned addr, input int unsigned wdata,
                                         input byte unsigned wmask);
    logic [31:0] w;
    wr_calls = wr_calls + 1;
    w = pmem.exists(addr) ? pmem[addr] : 32'h0;
    for (int b = 0; b < 4; b++) begin
      if (wmask[b]) w[b*8 +: 8] = wdata[b*8 +: 8];
    end
    pmem[addr] = w;
  endfunction

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // Window bounds in 33 bits so BASE+SIZE cannot wrap.
  localparam logic [32:0]      WIN_LO   = {1'b0, BASE};
  localparam logic [32:0]      WIN_HI   = {1'b0, BASE} + {1'b0, SIZE} - 33'd4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             l_wen, l_err;
  logic [31:0]      l_addr, l_wdata;
  logic [3:0]       l_wmask;
  logic             accept, do_access;
  logic             a_wen, a_err;
  logic [31:0]      a_addr, a_wdata;
  logic [3:0]       a_wmask;

  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({1'b0, a} < WIN_LO) || ({1'b0, a} > WIN_HI);
  endfunction

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = (state != IDLE);
    do_access  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (LATENCY == 1) begin
            do_access = 1'b1;
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          do_access = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = req_valid && req_ready;

  // With LATENCY==1 the access happens on the acceptance edge, before the latches hold anything.
  assign a_wen   = (state == IDLE) ? req_wen            : l_wen;
  assign a_addr  = (state == IDLE) ? req_addr           : l_addr;
  assign a_wdata = (state == IDLE) ? req_wdata          : l_wdata;
  assign a_wmask = (state == IDLE) ? req_wmask          : l_wmask;
  assign a_err   = (state == IDLE) ? addr_err(req_addr) : l_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      l_wen      <= 1'b0;
      l_err      <= 1'b0;
      l_addr     <= 32'h0;
      l_wdata    <= 32'h0;
      l_wmask    <= 4'h0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        l_wen   <= req_wen;
        l_err   <= addr_err(req_addr);
        l_addr  <= req_addr;
        l_wdata <= req_wdata;
        l_wmask <= req_wmask;
        cnt     <= CNT_LOAD;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end

      if (do_access) begin
        if (a_err) begin
          resp_err   <= 1'b1;
          resp_rdata <= 32'h0;
        end else if (!a_wen) begin
          resp_err   <= 1'b0;
          resp_rdata <= dpi_pmem_read(a_addr);
        end else begin
          if (a_wmask != 4'h0) dpi_pmem_write(a_addr, a_wdata, {4'b0, a_wmask});
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0;
        end
      end else if (state == RESP && resp_ready) begin
        resp_err   <= 1'b0;
        resp_rdata <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_dpi_mem_ctrl.sv
// tb/tb_dpi_mem_ctrl.sv - directed bench for dpi_mem_ctrl at LATENCY 1, 4 and 3
// Instance 0: LATENCY=1, instance 1: LATENCY=4, instance 2: LATENCY=3.
module tb_dpi_mem_ctrl;

  logic        clk;
  logic        rst_n      [3];
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_wen    [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic [3:0]  req_wmask  [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [31:0] resp_rdata [3];
  logic        resp_err   [3];
  logic        busy       [3];

  int errors = 0;
  int checks = 0;

  dpi_mem_ctrl #(.LATENCY(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_wen(req_wen[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_wmask(req_wmask[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .busy(busy[0])
  );

  dpi_mem_ctrl #(.LATENCY(4)) u_lat4 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_wen(req_wen[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_wmask(req_wmask[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .busy(busy[1])
  );

  dpi_mem_ctrl #(.LATENCY(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_wen(req_wen[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .req_wmask(req_wmask[2]), .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
    .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]), .busy(busy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int unsigned rdc(input int i);
    case (i)
      0:       return u_lat1.rd_calls;
      1:       return u_lat4.rd_calls;
      default: return u_lat3.rd_calls;
    endcase
  endfunction

  function automatic int unsigned wrc(input int i);
    case (i)
      0:       return u_lat1.wr_calls;
      1:       return u_lat4.wr_calls;
      default: return u_lat3.wr_calls;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one request at a negedge; returns #1 after the acceptance edge with req_* scrambled.
  task automatic send(input int i, input logic wen, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] wmask);
    @(negedge clk);
    req_valid[i] = 1'b1;
    req_wen[i]   = wen;
    req_addr[i]  = addr;
    req_wdata[i] = wdata;
    req_wmask[i] = wmask;
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
    req_wen[i]   = ~wen;
    req_addr[i]  = 32'hFFFF_FFF3;
    req_wdata[i] = $urandom;
    req_wmask[i] = 4'hF;
  endtask

  // Counts further edges after acceptance until resp_valid, bounded.
  task automatic wait_resp(input int i, output int n);
    n = 0;
    while (!resp_valid[i] && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic finish_resp(input int i, input string tag);
    @(negedge clk);
    resp_ready[i] = 1'b1;
    @(posedge clk);
    #1;
    resp_ready[i] = 1'b0;
    chk({tag, "_valid_clr"}, resp_valid[i], 1'b0);
    chk({tag, "_ready_back"}, req_ready[i], 1'b1);
    chk({tag, "_rdata_clr"}, resp_rdata[i], 32'h0);
  endtask

  int          n;
  int unsigned r0, w0;

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; req_valid[i] = 1'b0; req_wen[i] = 1'b0; req_addr[i] = 32'h0;
      req_wdata[i] = 32'h0; req_wmask[i] = 4'h0; resp_ready[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_req_ready", req_ready[i], 1'b1);
      chk("rst_resp_valid", resp_valid[i], 1'b0);
      chk("rst_rdata", resp_rdata[i], 32'h0);
      chk("rst_err", resp_err[i], 1'b0);
      chk("rst_busy", busy[i], 1'b0);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

    // LATENCY=1 write then read
    w0 = wrc(0);
    send(0, 1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 4'hF);
    wait_resp(0, n);
    chk("t1_wr_lat", n, 0);
    chk("t1_wr_calls", wrc(0) - w0, 1);
    finish_resp(0, "t1w");
    r0 = rdc(0);
    send(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0);
    wait_resp(0, n);
    chk("t1_rd_lat", n, 0);
    chk("t1_req_ready_low", req_ready[0], 1'b0);
    chk("t1_rdata", resp_rdata[0], 32'hDEAD_BEEF);
    chk("t1_err", resp_err[0], 1'b0);
    chk("t1_rd_calls", rdc(1'b0 ? 1 : 0) - r0, 1);
    finish_resp(0, "t1r");

    // LATENCY=4 partial write, call lands on E3
    send(1, 1'b1, 32'h8000_0010, 32'hAAAA_AAAA, 4'hF);
    wait_resp(1, n);
    finish_resp(1, "t2pre");
    w0 = wrc(1);
    send(1, 1'b1, 32'h8000_0010, 32'h1122_3344, 4'b0011);
    @(posedge clk); #1;
    chk("t2_e1_valid", resp_valid[1], 1'b0);
    @(posedge clk); #1;
    chk("t2_e2_valid", resp_valid[1], 1'b0);
    chk("t2_e2_calls", wrc(1) - w0, 0);
    @(posedge clk); #1;
    chk("t2_e3_valid", resp_valid[1], 1'b1);
    chk("t2_e3_calls", wrc(1) - w0, 1);
    chk("t2_rdata", resp_rdata[1], 32'h0);
    chk("t2_err", resp_err[1], 1'b0);
    finish_resp(1, "t2w");
    send(1, 1'b0, 32'h8000_0010, 32'h0, 4'h0);
    wait_resp(1, n);
    chk("t2_rd_lat", n, 3);
    chk("t2_rd_merge", resp_rdata[1], 32'hAAAA_3344);
    finish_resp(1, "t2r");

    // address window and alignment
    r0 = rdc(0);
    w0 = wrc(0);
    send(0, 1'b0, 32'h8000_0002, 32'h0, 4'h0);
    wait_resp(0, n);
    chk("t3_mis_err", resp_err[0], 1'b1);
    chk("t3_mis_rdata", resp_rdata[0], 32'h0);
    finish_resp(0, "t3a");
    chk("t3_err_clr", resp_err[0], 1'b0);
    send(0, 1'b1, 32'h7FFF_FFFC, 32'h1234_5678, 4'hF);
    wait_resp(0, n);
    chk("t3_low_err", resp_err[0], 1'b1);
    finish_resp(0, "t3b");
    send(0, 1'b1, 32'h8800_0000, 32'h1234_5678, 4'hF);
    wait_resp(0, n);
    chk("t3_high_err", resp_err[0], 1'b1);
    chk("t3_high_rdata", resp_rdata[0], 32'h0);
    finish_resp(0, "t3c");
    chk("t3_no_rd", rdc(0) - r0, 0);
    chk("t3_no_wr", wrc(0) - w0, 0);
    send(0, 1'b0, 32'h87FF_FFFC, 32'h0, 4'h0);
    wait_resp(0, n);
    chk("t3_last_err", resp_err[0], 1'b0);
    chk("t3_last_rdata", resp_rdata[0], 32'h0);
    chk("t3_last_rd", rdc(0) - r0, 1);
    finish_resp(0, "t3d");

    // back-pressure with ignored request pulses
    w0 = wrc(0);
    send(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0);
    wait_resp(0, n);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req_valid[0] = 1'b1; req_wen[0] = 1'b1; req_addr[0] = 32'h8000_0000;
      req_wdata[0] = 32'h0; req_wmask[0] = 4'hF;
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      chk("t4_valid_held", resp_valid[0], 1'b1);
      chk("t4_rdata_held", resp_rdata[0], 32'hDEAD_BEEF);
      chk("t4_err_held", resp_err[0], 1'b0);
      chk("t4_ready_low", req_ready[0], 1'b0);
    end
    chk("t4_no_wr", wrc(0) - w0, 0);
    finish_resp(0, "t4");
    chk("t4_idle", busy[0], 1'b0);

    // asynchronous reset during WAIT drops the request
    send(2, 1'b1, 32'h8000_0020, 32'h0000_0055, 4'hF);
    chk("t5_busy_wait", busy[2], 1'b1);
    #2;
    rst_n[2] = 1'b0;
    #1;
    chk("t5_async_busy", busy[2], 1'b0);
    chk("t5_async_ready", req_ready[2], 1'b1);
    chk("t5_async_valid", resp_valid[2], 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_no_wr", wrc(2), 0);
    @(negedge clk);
    rst_n[2] = 1'b1;
    send(2, 1'b0, 32'h8000_0020, 32'h0, 4'h0);
    wait_resp(2, n);
    chk("t5_rd_lat", n, 2);
    chk("t5_rdata", resp_rdata[2], 32'h0);
    chk("t5_rd_calls", rdc(2), 1);
    finish_resp(2, "t5");

    // zero write mask: normal response, no model call
    w0 = wrc(1);
    send(1, 1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0);
    wait_resp(1, n);
    chk("t6_lat", n, 3);
    chk("t6_err", resp_err[1], 1'b0);
    chk("t6_rdata", resp_rdata[1], 32'h0);
    chk("t6_no_wr", wrc(1) - w0, 0);
    finish_resp(1, "t6w");
    send(1, 1'b0, 32'h8000_0010, 32'h0, 4'h0);
    wait_resp(1, n);
    chk("t6_unchanged", resp_rdata[1], 32'hAAAA_3344);
    finish_resp(1, "t6r");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dpi_mem_ctrl.md
Name: dpi_mem_ctrl

Overview:
- Simulation-only memory controller backing the core's instruction/data port with the DPI-C physical-memory functions `dpi_pmem_read` and `dpi_pmem_write`.
- Successor to the level-triggered DPI memory block, adding:
  - valid/ready handshakes on separate request and response channels;
  - a parametrised fixed access latency;
  - an address window with error reporting;
  - a strictly clocked DPI call point, exactly one call per accepted request.
- Sits between the LSU/IFU bus master and the DPI memory model.
- At most one request is in flight at a time.

Parameters:
- LATENCY, default 1: cycles from request acceptance edge to resp_valid asserting; legal range 1..16.
- BASE, default 32'h8000_0000: first byte address of the legal window.
- SIZE, default 32'h0800_0000: window size in bytes; must be a non-zero multiple of 4.
- CNT_W, default 5: width of the internal latency counter; must hold LATENCY-1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_wen  input  1  1 = write, 0 = read.
- req_addr  input  32  byte address, shared by reads and writes.
- req_wdata  input  32  write data.
- req_wmask  input  4  byte-lane enables; zero-extended to the 8-bit DPI wmask.
- resp_valid  output  1  response present.
- resp_ready  input  1  master accepts the response.
- resp_rdata  output  32  read data; 0 for writes and errors.
- resp_err  output  1  request was misaligned or outside the window.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - State is IDLE; the latency counter is 0.
  - req_ready=1 (after reset deasserts), resp_valid=0, resp_rdata=0, resp_err=0, busy=0.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On the edge where req_valid && req_ready, latch wen, addr, wdata and wmask, and compute err.
  - err = (addr[1:0] != 0) || (addr < BASE) || (addr > BASE+SIZE-4). Compare in 33 bits so BASE+SIZE does not wrap.
  - If LATENCY==1: go to RESP and perform the access on this same edge.
  - Otherwise: go to WAIT and load the counter with LATENCY-2.
- WAIT:
  - req_ready=0.
  - If the counter is 0: perform the access and go to RESP.
  - Otherwise: decrement the counter.
- Access (performed exactly once, on the edge that enters RESP):
  - err=1: no DPI call; resp_err<=1; resp_rdata<=0.
  - Read: resp_rdata <= dpi_pmem_read(addr).
  - Write: dpi_pmem_write(addr, wdata, {4'b0, wmask}); resp_rdata<=0. If wmask==0, no DPI call, but a normal response is still returned.
- RESP:
  - resp_valid=1. resp_rdata and resp_err are held stable until the handshake.
  - On resp_valid && resp_ready: go to IDLE, clear resp_valid, resp_rdata and resp_err.
  - req_ready stays 0 throughout RESP, so no request overlaps a pending response.
- Throughput: one request per LATENCY+1 cycles when resp_ready is held high.
- Request stability: req_* may change after the acceptance edge; only latched copies are used.
- Reset mid-operation:
  - Asserting rst_n=0 in WAIT drops the request; its DPI call never happens.
  - Asserting rst_n=0 in RESP discards the response; the DPI side effect has already occurred.
- Unused inputs: req_valid while busy is ignored (not queued); req_wdata and req_wmask are ignored on reads.
- Elaboration checks: LATENCY outside 1..16, or SIZE not a multiple of 4, is an elaboration error.

Test Plan:
1. LATENCY=1; memory word at 0x8000_0000 = 0xDEAD_BEEF; read request at edge E0 -> resp_valid=1 after E0, resp_rdata=0xDEAD_BEEF, resp_err=0, exactly one dpi_pmem_read call; req_ready=0 until the handshake, then back to 1.
2. LATENCY=4; write addr=0x8000_0010, wdata=0x1122_3344, wmask=4'b0011 accepted at E0 -> dpi_pmem_write called once at E3, resp_valid rises after E3, resp_rdata=0; a following read of the same address returns the updated low half.
3. Misaligned read 0x8000_0002, then out-of-range write 0x7FFF_FFFC and 0x8800_0000 (defaults) -> resp_err=1, resp_rdata=0, zero DPI calls; the last legal word 0x87FF_FFFC gives resp_err=0.
4. Back-pressure: hold resp_ready=0 for 5 cycles after resp_valid -> resp_valid, resp_rdata and resp_err remain stable; req_valid pulses are not accepted; resp_ready=1 -> IDLE on the next edge.
5. LATENCY=3; assert rst_n=0 asynchronously during WAIT -> outputs reset immediately with no clock edge; no DPI call for the dropped request; the next request after reset completes normally.
6. Write with wmask=0 -> no DPI call, resp_valid after LATENCY cycles, resp_err=0.
